// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_if
// Brief    : Control/status bundle between the IF-stage PC generator and the
//            hazard, branch, trap and debug logic that steers it.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic            halt_req;
    logic            resume;
    logic [XLEN-1:0] pc_out;
    logic            fetch_valid;
    logic            redirect_pending;
    logic            halted;
    logic            misalign_err;

    modport master (
        output stall, redirect_valid, redirect_target, trap_valid, halt_req, resume,
        input  pc_out, fetch_valid, redirect_pending, halted, misalign_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap_valid, halt_req, resume,
        output pc_out, fetch_valid, redirect_pending, halted, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : IF-stage program counter with stall, buffered redirect, trap
//            vectoring, debug halt/resume and target alignment checking.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00000000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h00000100,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_gen_if.slave   bus
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
    localparam logic [XLEN-1:0] c_INC        = XLEN'(INC);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_pend;
    logic            w_pend_nxt;
    logic [XLEN-1:0] r_ptgt;
    logic [XLEN-1:0] w_ptgt_nxt;
    logic            r_mis;
    logic            w_mis_nxt;
    logic [XLEN-1:0] w_tgt;
    logic            w_misaligned;

    assign w_tgt        = bus.redirect_target & ~c_ALIGN_MASK;
    assign w_misaligned = |(bus.redirect_target & c_ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_VECTOR;
            r_pend  <= 1'b0;
            r_ptgt  <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_ptgt  <= w_ptgt_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_ptgt_nxt  = r_ptgt;
        w_mis_nxt   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (bus.trap_valid) begin
                    w_pc_nxt   = TRAP_VECTOR;
                    w_pend_nxt = 1'b0;
                    if (bus.halt_req) w_state_nxt = S_HALT;
                end else begin
                    w_mis_nxt = bus.redirect_valid && w_misaligned;
                    // Halt entry: an unstalled redirect still lands, anything buffered is dropped
                    if (bus.halt_req) begin
                        w_state_nxt = S_HALT;
                        w_pend_nxt  = 1'b0;
                        if (bus.redirect_valid && !bus.stall) w_pc_nxt = w_tgt;
                    end else if (bus.redirect_valid) begin
                        if (bus.stall) begin
                            w_pend_nxt = 1'b1;
                            w_ptgt_nxt = w_tgt;
                        end else begin
                            w_pc_nxt   = w_tgt;
                            w_pend_nxt = 1'b0;
                        end
                    end else if (bus.stall) begin
                        w_pc_nxt = r_pc;
                    end else if (r_pend) begin
                        w_pc_nxt   = r_ptgt;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_pc_nxt = r_pc + c_INC;
                    end
                end
            end
            S_HALT: begin
                w_pend_nxt = 1'b0;
                if (bus.trap_valid) begin
                    w_pc_nxt    = TRAP_VECTOR;
                    w_state_nxt = S_RUN;
                end else begin
                    w_mis_nxt = bus.redirect_valid && w_misaligned;
                    if (bus.redirect_valid) w_pc_nxt = w_tgt;
                    if (bus.resume) w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign bus.pc_out           = r_pc;
    assign bus.fetch_valid      = !rst && (r_state == S_RUN);
    assign bus.halted           = (r_state == S_HALT);
    assign bus.redirect_pending = r_pend;
    assign bus.misalign_err     = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Scoreboarded bench for pc_gen: directed scenarios then random
//            traffic against a behavioural model; a second instance checks wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] c_RV  = 32'h00000000;
    localparam logic [31:0] c_RV2 = 32'hFFFFFFF8;
    localparam logic [31:0] c_TV  = 32'h00000100;

    logic clk;
    logic rst;

    pc_gen_if #(.XLEN(32)) u_if ();
    pc_gen_if #(.XLEN(32)) u_if2 ();

    pc_gen #(.XLEN(32), .RESET_VECTOR(c_RV), .TRAP_VECTOR(c_TV), .INC(4), .ALIGN_BITS(2))
        u_dut (.clk(clk), .rst(rst), .bus(u_if));

    pc_gen #(.XLEN(32), .RESET_VECTOR(c_RV2), .TRAP_VECTOR(c_TV), .INC(4), .ALIGN_BITS(2))
        u_dut_wrap (.clk(clk), .rst(rst), .bus(u_if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          full;
        bit          fv_chk;
        logic [31:0] pc;
        logic [31:0] pc2;
        bit          pend;
        bit          halt;
        bit          mis;
        bit          fv;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the architectural view of the fetch unit
    bit          m_known = 0;
    logic [31:0] m_pc, m_pc2, m_ptgt;
    bit          m_pend, m_halt, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit rv, input logic [31:0] rt,
                         input bit tr, input bit hq, input bit rs);
        exp_t        e;
        logic [31:0] tgt;
        bit          bad;
        rst                   = r;
        u_if.stall            = s;
        u_if.redirect_valid   = rv;
        u_if.redirect_target  = rt;
        u_if.trap_valid       = tr;
        u_if.halt_req         = hq;
        u_if.resume           = rs;
        e.full   = m_known;
        e.fv_chk = m_known || r;
        e.pc     = m_pc;
        e.pc2    = m_pc2;
        e.pend   = m_pend;
        e.halt   = m_halt;
        e.mis    = m_mis;
        e.fv     = !r && !m_halt;
        q.push_back(e);
        @(posedge clk);
        tgt = {rt[31:2], 2'b00};
        bad = (rt % 4) != 0;
        if (r) begin
            m_known = 1;
            m_pc = c_RV; m_pc2 = c_RV2; m_ptgt = '0;
            m_pend = 0; m_halt = 0; m_mis = 0;
        end else if (m_known) begin
            m_pc2 = m_pc2 + 32'd4;
            m_mis = rv && !tr && bad;
            if (tr) begin
                m_pc = c_TV; m_pend = 0;
                m_halt = m_halt ? 0 : hq;
            end else if (m_halt) begin
                if (rv) m_pc = tgt;
                if (rs) m_halt = 0;
            end else if (hq) begin
                if (rv && !s) m_pc = tgt;
                m_pend = 0; m_halt = 1;
            end else if (rv && s) begin
                m_pend = 1; m_ptgt = tgt;
            end else if (rv) begin
                m_pc = tgt; m_pend = 0;
            end else if (!s) begin
                if (m_pend) begin m_pc = m_ptgt; m_pend = 0; end
                else m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 32'h0, 0, 0, 0);
        cycle(1, 0, 0, 32'h0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.fv_chk) chk("fetch_valid", 32'(u_if.fetch_valid), 32'(e.fv));
                if (e.full) begin
                    chk("pc_out", u_if.pc_out, e.pc);
                    chk("redirect_pending", 32'(u_if.redirect_pending), 32'(e.pend));
                    chk("halted", 32'(u_if.halted), 32'(e.halt));
                    chk("misalign_err", 32'(u_if.misalign_err), 32'(e.mis));
                    chk("wrap_pc_out", u_if2.pc_out, e.pc2);
                end
            end
        end
    end

    initial begin
        u_if2.stall = 0; u_if2.redirect_valid = 0; u_if2.redirect_target = '0;
        u_if2.trap_valid = 0; u_if2.halt_req = 0; u_if2.resume = 0;
        rst = 1;
        u_if.stall = 0; u_if.redirect_valid = 0; u_if.redirect_target = '0;
        u_if.trap_valid = 0; u_if.halt_req = 0; u_if.resume = 0;
        @(posedge clk);
        #1;

        // Reset then sequential run; also covers the wrap instance
        do_reset();
        idle(4);

        // Buffered redirect, last one wins
        do_reset();
        idle(2);
        cycle(0, 1, 1, 32'h40, 0, 0, 0);
        cycle(0, 1, 1, 32'h80, 0, 0, 0);
        cycle(0, 1, 0, 32'h0, 0, 0, 0);
        idle(3);

        // Trap beats stall and redirect
        cycle(0, 1, 1, 32'h40, 1, 0, 0);
        idle(2);

        // Misaligned redirect is truncated
        cycle(0, 0, 1, 32'h46, 0, 0, 0);
        idle(2);

        // Halt, debug PC write, resume
        do_reset();
        idle(4);
        cycle(0, 0, 0, 32'h0, 0, 1, 0);
        cycle(0, 1, 0, 32'h0, 0, 0, 0);
        cycle(0, 0, 1, 32'h200, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 32'h0, 0, 0, 1);
        idle(3);

        // Redirect and halt together, then trap out of halt
        cycle(0, 0, 1, 32'h300, 0, 1, 0);
        idle(1);
        cycle(0, 0, 0, 32'h0, 1, 0, 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(99) < 2), ($urandom_range(99) < 30), ($urandom_range(99) < 20),
                  $urandom(), ($urandom_range(99) < 5), ($urandom_range(99) < 5),
                  ($urandom_range(99) < 15));
        end
        idle(2);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
